pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder_pkg.sv | 16 +
 rtl/pe_filter_bank.sv | 48 ++++
 rtl/pe_feeder.sv | 160 ++++++++++++++++
 tb/tb_pe_feeder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
// Shared constants and state encoding for the PE feeder and its filter bank.
package pe_feeder_pkg;

  localparam int KERNEL_TAPS  = 9;
  localparam int WAIT_TIMEOUT = 15;

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/pe_filter_bank.sv
// Tap weight register file: one write port, one combinational read port.
module pe_filter_bank #(
  parameter int TAPS = pe_feeder_pkg::KERNEL_TAPS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_data
);

  logic [7:0] taps_q [TAPS];
  logic [7:0] taps_d [TAPS];

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      taps_d[i] = taps_q[i];
      if (wr_en && (wr_addr == 4'(i))) begin
        taps_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        taps_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        taps_q[i] <= taps_d[i];
      end
    end
  end

  // Indices beyond the last tap read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (rd_idx == 4'(i)) begin
        rd_data = taps_q[i];
      end
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Streams one captured 3x3 window and its filter taps into a PE, one pair per
// cycle, then waits for the PE's completion flag or times out.
module pe_feeder #(
  parameter int KERNEL_TAPS  = pe_feeder_pkg::KERNEL_TAPS,
  parameter int WAIT_TIMEOUT = pe_feeder_pkg::WAIT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     filt_wr_en,
  input  logic [3:0]               filt_wr_addr,
  input  logic [7:0]               filt_wr_data,
  input  logic                     win_valid,
  input  logic [8*KERNEL_TAPS-1:0] win_data,
  output logic                     win_ready,
  output logic [7:0]               pe_in,
  output logic [7:0]               pe_filter,
  output logic [1:0]               mode_o,
  input  logic                     single_count_9,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  import pe_feeder_pkg::*;

  localparam logic [3:0] LAST_TAP     = 4'(KERNEL_TAPS - 1);
  localparam logic [3:0] TIMEOUT_LAST = 4'(WAIT_TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic [3:0]               wait_cnt_q, wait_cnt_d;
  logic [8*KERNEL_TAPS-1:0] win_buf_q, win_buf_d;
  logic                     filt_loaded_q, filt_loaded_d;
  logic [7:0]               pe_in_q, pe_in_d;
  logic [7:0]               pe_filter_q, pe_filter_d;
  logic [1:0]               mode_q, mode_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic       accept;
  logic       filt_wr_ok;
  logic [3:0] nxt_idx;
  logic [3:0] rd_idx;
  logic [7:0] tap_rd;
  logic [7:0] nxt_pix;

  assign win_ready  = (state_q == ST_IDLE) && filt_loaded_q;
  assign accept     = win_valid && win_ready;
  assign filt_wr_ok = (state_q == ST_IDLE) && filt_wr_en && (filt_wr_addr <= LAST_TAP);
  assign nxt_idx    = idx_q + 4'd1;
  // Outputs are registered, so the bank is read one tap ahead of what is shown.
  assign rd_idx     = accept ? 4'd0 : nxt_idx;

  pe_filter_bank #(
    .TAPS(KERNEL_TAPS)
  ) u_filter_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (filt_wr_ok),
    .wr_addr (filt_wr_addr),
    .wr_data (filt_wr_data),
    .rd_idx  (rd_idx),
    .rd_data (tap_rd)
  );

  always_comb begin
    nxt_pix = '0;
    for (int i = 0; i < KERNEL_TAPS; i++) begin
      if (nxt_idx == 4'(i)) begin
        nxt_pix = win_buf_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_cnt_d    = wait_cnt_q;
    win_buf_d     = win_buf_q;
    filt_loaded_d = filt_loaded_q || (filt_wr_ok && (filt_wr_addr == LAST_TAP));
    pe_in_d       = '0;
    pe_filter_d   = '0;
    mode_d        = MODE_IDLE;
    done_d        = 1'b0;
    err_d         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          win_buf_d   = win_data;
          state_d     = ST_STREAM;
          idx_d       = 4'd0;
          pe_in_d     = win_data[7:0];
          pe_filter_d = tap_rd;
          mode_d      = MODE_SINGLE;
        end
      end
      ST_STREAM: begin
        if (idx_q >= LAST_TAP) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 4'd0;
        end else begin
          idx_d       = nxt_idx;
          pe_in_d     = nxt_pix;
          pe_filter_d = tap_rd;
          mode_d      = MODE_SINGLE;
        end
      end
      ST_WAIT: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (single_count_9) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_cnt_q != 4'hF) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      wait_cnt_q    <= '0;
      win_buf_q     <= '0;
      filt_loaded_q <= 1'b0;
      pe_in_q       <= '0;
      pe_filter_q   <= '0;
      mode_q        <= MODE_IDLE;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wait_cnt_q    <= wait_cnt_d;
      win_buf_q     <= win_buf_d;
      filt_loaded_q <= filt_loaded_d;
      pe_in_q       <= pe_in_d;
      pe_filter_q   <= pe_filter_d;
      mode_q        <= mode_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign pe_in     = pe_in_q;
  assign pe_filter = pe_filter_q;
  assign mode_o    = mode_q;
  assign busy      = (state_q == ST_STREAM) || (state_q == ST_WAIT);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: scoreboard of expected pixel/weight pairs
// plus directed checks on handshake, completion, timeout and reset behaviour.
module tb_pe_feeder;

  import pe_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        filt_wr_en;
  logic [3:0]  filt_wr_addr;
  logic [7:0]  filt_wr_data;
  logic        win_valid;
  logic [71:0] win_data;
  logic        win_ready;
  logic [7:0]  pe_in;
  logic [7:0]  pe_filter;
  logic [1:0]  mode_o;
  logic        single_count_9;
  logic        busy;
  logic        done;
  logic        err;

  pe_feeder dut (
    .clk            (clk),
    .rst            (rst),
    .filt_wr_en     (filt_wr_en),
    .filt_wr_addr   (filt_wr_addr),
    .filt_wr_data   (filt_wr_data),
    .win_valid      (win_valid),
    .win_data       (win_data),
    .win_ready      (win_ready),
    .pe_in          (pe_in),
    .pe_filter      (pe_filter),
    .mode_o         (mode_o),
    .single_count_9 (single_count_9),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  logic [15:0] sb_q [$];
  logic [7:0]  taps_model [9];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int exp_done = 0;
  int exp_err = 0;
  int extra_products = 0;
  bit mon_en = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [71:0] randWindow();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[71:0];
  endfunction

  // Products appear on the negative edge; each one must match the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (mode_o == MODE_SINGLE) begin
        if (sb_q.size() == 0) begin
          extra_products++;
        end else begin
          logic [15:0] e;
          e = sb_q.pop_front();
          checkOutput("stream_pe_in", pe_in, e[15:8]);
          checkOutput("stream_pe_filter", pe_filter, e[7:0]);
        end
      end else begin
        checkOutput("idle_mode", mode_o, MODE_IDLE);
        checkOutput("idle_pe_outputs", {pe_in, pe_filter}, 16'h0);
      end
    end
  end

  task automatic loadTap(input logic [3:0] addr, input logic [7:0] data);
    filt_wr_en   = 1'b1;
    filt_wr_addr = addr;
    filt_wr_data = data;
    tick();
    filt_wr_en   = 1'b0;
  endtask

  // Hands one window over and leaves the bench in cycle T+1.
  task automatic applyStimulus(input logic [71:0] pix);
    int guard;
    guard = 0;
    while (!win_ready && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput("win_ready_seen", win_ready, 1);
    win_valid = 1'b1;
    win_data  = pix;
    for (int k = 0; k < 9; k++) begin
      sb_q.push_back({pix[8*k +: 8], taps_model[k]});
    end
    tick();
    win_valid = 1'b0;
    checkOutput("accept_busy", busy, 1);
    checkOutput("accept_ready_low", win_ready, 0);
    checkOutput("first_pe_in", pe_in, pix[7:0]);
    checkOutput("first_mode", mode_o, MODE_SINGLE);
  endtask

  task automatic streamToWait();
    tick(9);
    checkOutput("wait_mode", mode_o, MODE_IDLE);
    checkOutput("wait_busy", busy, 1);
    checkOutput("wait_ready_low", win_ready, 0);
  endtask

  task automatic waitDone(input int delay);
    tick(delay);
    single_count_9 = 1'b1;
    tick();
    single_count_9 = 1'b0;
    exp_done++;
    checkOutput("done_pulse", done, 1);
    checkOutput("done_no_err", err, 0);
    checkOutput("done_not_busy", busy, 0);
    tick();
    checkOutput("done_one_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic [71:0] w;
    rst            = 1'b1;
    filt_wr_en     = 1'b0;
    filt_wr_addr   = '0;
    filt_wr_data   = '0;
    win_valid      = 1'b0;
    win_data       = '0;
    single_count_9 = 1'b0;
    for (int k = 0; k < 9; k++) taps_model[k] = '0;
    tick(2);
    rst = 1'b0;
    checkOutput("rst_win_ready", win_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_pe_in", pe_in, 0);
    checkOutput("rst_pe_filter", pe_filter, 0);
    checkOutput("rst_mode", mode_o, MODE_IDLE);
    mon_en = 1'b1;

    // No filter loaded: window offered but never accepted.
    win_valid = 1'b1;
    win_data  = {9{8'h11}};
    repeat (3) begin
      tick();
      checkOutput("noload_ready", win_ready, 0);
      checkOutput("noload_busy", busy, 0);
    end
    win_valid = 1'b0;

    // Flag in IDLE must be ignored.
    single_count_9 = 1'b1;
    tick();
    single_count_9 = 1'b0;

    for (int k = 0; k < 9; k++) begin
      loadTap(4'(k), 8'(k + 1));
      taps_model[k] = 8'(k + 1);
      if (k < 8) checkOutput("partial_load_ready", win_ready, 0);
    end
    loadTap(4'd12, 8'hEE);
    checkOutput("loaded_ready", win_ready, 1);

    // Pixels 1..9 against taps 1..9.
    applyStimulus(72'h09_08_07_06_05_04_03_02_01);
    streamToWait();
    waitDone(0);

    // Timeout: no flag, err after 15 WAIT cycles.
    applyStimulus(randWindow());
    streamToWait();
    n = 0;
    do begin
      tick();
      n++;
    end while (!err && n < 30);
    exp_err++;
    checkOutput("timeout_cycles", n, 15);
    checkOutput("timeout_not_busy", busy, 0);
    tick();
    checkOutput("err_one_cycle", err, 0);
    checkOutput("ready_after_err", win_ready, 1);

    // Tap write during STREAM ignored; stray flag during STREAM ignored too.
    applyStimulus(randWindow());
    filt_wr_en     = 1'b1;
    filt_wr_addr   = 4'd3;
    filt_wr_data   = 8'hFF;
    single_count_9 = 1'b1;
    tick();
    filt_wr_en     = 1'b0;
    single_count_9 = 1'b0;
    tick(8);
    checkOutput("stream_write_wait_busy", busy, 1);
    waitDone(3);
    applyStimulus(randWindow());
    tick(3);
    checkOutput("tap3_kept", pe_filter, 8'd4);
    tick(6);
    checkOutput("tap3_wait_busy", busy, 1);
    waitDone(0);

    // Completion coincident with the final timeout cycle: done wins.
    applyStimulus(randWindow());
    streamToWait();
    waitDone(14);

    // Reset at T+5 aborts the window with no pulse and clears taps.
    applyStimulus(randWindow());
    tick(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    checkOutput("abort_pe_in", pe_in, 0);
    checkOutput("abort_pe_filter", pe_filter, 0);
    checkOutput("abort_mode", mode_o, MODE_IDLE);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_err", err, 0);
    checkOutput("abort_filt_loaded", win_ready, 0);
    tick(20);
    for (int k = 0; k < 9; k++) taps_model[k] = '0;
    loadTap(4'd8, 8'h07);
    taps_model[8] = 8'h07;
    w = randWindow();
    applyStimulus(w);
    streamToWait();
    waitDone(0);

    tick(2);
    checkOutput("done_count", done_cnt, exp_done);
    checkOutput("err_count", err_cnt, exp_err);
    checkOutput("unexpected_products", extra_products, 0);
    checkOutput("sb_leftover", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
